wb_initiator: RTL

Single-outstanding Wishbone B4 pipelined initiator that turns a valid/ready request stream into Wishbone cycles and returns each result on a valid/ready response stream. It drives the register banks generated for the design, including their `wb_stall_o`/`wb_ack_o`/`wb_err_o`/`wb_rty_o` behaviour. It sits between firmware-side command logic, or a host bridge, and the Wishbone interconnect.

---
 rtl/wb_initiator_pkg.sv | 30 +++
 rtl/wb_initiator_timeout.sv | 33 +++
 rtl/wb_initiator.sv | 130 +++++++++++++
 3 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared types and response codes for the single-outstanding Wishbone initiator.
// Used by wb_initiator and wb_initiator_timeout.
package wb_initiator_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STROBE = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam logic [1:0] RSP_OK      = 2'b00;
   localparam logic [1:0] RSP_ERR     = 2'b01;
   localparam logic [1:0] RSP_RTY     = 2'b10;
   localparam logic [1:0] RSP_TIMEOUT = 2'b11;

   // Collapse simultaneous terminations: err beats rty beats ack.
   function automatic logic [1:0] term_code(input logic err, input logic rty);
      logic [1:0] code;
      if (err) begin
         code = RSP_ERR;
      end else if (rty) begin
         code = RSP_RTY;
      end else begin
         code = RSP_OK;
      end
      return code;
   endfunction

endpackage

// File: rtl/wb_initiator_timeout.sv
// Saturating cycle counter for the Wishbone initiator; present only when
// WB_INITIATOR_TIMEOUT_EN is defined.
module wb_initiator_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned   CW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_r;

   // Count cycles spent with the bus cycle open, holding at the limit
   always_ff @(posedge clk_i) begin
      if (rst_i || clear) begin
         count_r <= {CW{1'b0}};
      end else if (run && (count_r != LIMIT)) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // Fires in the cycle whose closing edge brings the count to the limit.
   assign expired = run && (count_r >= LAST);

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone B4 pipelined initiator: valid/ready request in,
// one bus cycle, valid/ready response out. Timeout logic needs WB_INITIATOR_TIMEOUT_EN.
module wb_initiator
   import wb_initiator_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_data,
   input  logic [DATA_WIDTH/8-1:0] req_sel,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   input  logic                    wb_rty_i,
   input  logic                    wb_stall_i,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic [1:0]              rsp_code
);

   localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

   state_e     state_r;
   logic       accept_s;
   logic       term_s;
   logic       strobe_taken_s;
   logic       done_s;
   logic       expired_s;
   logic [1:0] code_s;

   assign req_ready      = (state_r == IDLE) && !rst_i;
   assign accept_s       = req_valid && req_ready;
   assign term_s         = wb_ack_i || wb_err_i || wb_rty_i;
   assign strobe_taken_s = (state_r == STROBE) && !wb_stall_i;
   // A termination only counts once the slave has taken the strobe.
   assign done_s         = term_s && (strobe_taken_s || (state_r == WAIT));
   assign code_s         = term_code(wb_err_i, wb_rty_i);

`ifdef WB_INITIATOR_TIMEOUT_EN
   logic busy_s;

   assign busy_s = (state_r == STROBE) || (state_r == WAIT);

   wb_initiator_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear   (accept_s),
      .run     (busy_s),
      .expired (expired_s)
   );
`else
   assign expired_s = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

   // Request/response sequencing with registered Wishbone and response outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= IDLE;
         wb_cyc_o  <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_adr_o  <= {ADDR_WIDTH{1'b0}};
         wb_dat_o  <= {DATA_WIDTH{1'b0}};
         wb_sel_o  <= {SEL_WIDTH{1'b0}};
         rsp_valid <= 1'b0;
         rsp_data  <= {DATA_WIDTH{1'b0}};
         rsp_code  <= RSP_OK;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  wb_we_o  <= req_we;
                  wb_adr_o <= req_addr;
                  wb_dat_o <= req_data;
                  wb_sel_o <= req_sel;
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  state_r  <= STROBE;
               end
            end
            STROBE, WAIT: begin
               if (done_s) begin
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_code  <= code_s;
                  rsp_data  <= ((code_s == RSP_OK) && !wb_we_o) ? wb_dat_i : {DATA_WIDTH{1'b0}};
                  state_r   <= RESP;
               end else if (expired_s) begin
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_code  <= RSP_TIMEOUT;
                  rsp_data  <= {DATA_WIDTH{1'b0}};
                  state_r   <= RESP;
               end else if (strobe_taken_s) begin
                  wb_stb_o  <= 1'b0;
                  state_r   <= WAIT;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
